// File: rtl/regfile_pkg.sv
// Shared register-file types: architectural widths and the write-back queue entry.
package regfile_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_bypass_match.sv
// Youngest-match finder over the write-back queue for one bypass query port.
module regfile_bypass_match
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t                entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [$clog2(DEPTH):0]   count,
  input  logic [REG_AW-1:0]        qa,
  output logic                     hit,
  output logic [XLEN-1:0]          data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    idx_s [DEPTH];
  logic [DEPTH-1:0] match_s;

  // Walk slots in age order; slot i is the i-th oldest queued entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      idx_s[i]   = head + AW'(i);
      match_s[i] = (CW'(i) < count) && (qa != {REG_AW{1'b0}}) &&
                   (entries[idx_s[i]].rd == qa);
    end
  end

  // Later matches override earlier ones, so the youngest write wins.
  always_comb begin
    hit  = |match_s;
    data = {XLEN{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      data = match_s[i] ? entries[idx_s[i]].data : data;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Two-lane write-back queue that serialises writes onto a single register-file
// write port, with queued-write bypass for two read addresses.
module regfile_wb_scheduler
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb0_valid,
  input  logic [REG_AW-1:0]      wb0_rd,
  input  logic [XLEN-1:0]        wb0_data,
  input  logic                   wb1_valid,
  input  logic [REG_AW-1:0]      wb1_rd,
  input  logic [XLEN-1:0]        wb1_data,
  output logic                   wb_ready,
  output logic                   rf_we,
  output logic [REG_AW-1:0]      rf_wa,
  output logic [XLEN-1:0]        rf_wd,
  input  logic [REG_AW-1:0]      qa1,
  input  logic [REG_AW-1:0]      qa2,
  output logic                   q1_hit,
  output logic [XLEN-1:0]        q1_data,
  output logic                   q2_hit,
  output logic [XLEN-1:0]        q2_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t     mem_r [DEPTH];
  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [CW-1:0] count_r;

  logic [CW-1:0]   free_s;
  logic            ready_s;
  logic            empty_s;
  logic            pop_s;
  logic            acc0_s;
  logic            acc1_s;
  logic [1:0]      push_cnt_s;
  logic [AW-1:0]   lane1_idx_s;
  wb_entry_t       head_s;
  logic            hit1_s;
  logic            hit2_s;
  logic [XLEN-1:0] data1_s;
  logic [XLEN-1:0] data2_s;

  // Acceptance and pop decisions, all based on occupancy before this edge.
  always_comb begin
    free_s      = CW'(DEPTH) - count_r;
    ready_s     = !rst && (free_s >= CW'(2));
    empty_s     = (count_r == {CW{1'b0}});
    pop_s       = !rst && !empty_s;
    acc0_s      = ready_s && wb0_valid && (wb0_rd != {REG_AW{1'b0}});
    acc1_s      = ready_s && wb1_valid && (wb1_rd != {REG_AW{1'b0}});
    push_cnt_s  = {1'b0, acc0_s} + {1'b0, acc1_s};
    lane1_idx_s = tail_r + AW'(acc0_s);
    head_s      = mem_r[head_r];
  end

  // Pointer and occupancy state; reset discards everything queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= {AW{1'b0}};
      tail_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      head_r  <= head_r + AW'(pop_s);
      tail_r  <= tail_r + AW'(push_cnt_s);
      count_r <= count_r + CW'(push_cnt_s) - CW'(pop_s);
    end
  end

  // Entry storage; lane 1 lands behind lane 0 only when lane 0 took a slot.
  always_ff @(posedge clk) begin
    if (acc0_s) begin
      mem_r[tail_r] <= '{rd: wb0_rd, data: wb0_data};
    end
    if (acc1_s) begin
      mem_r[lane1_idx_s] <= '{rd: wb1_rd, data: wb1_data};
    end
  end

  regfile_bypass_match #(.DEPTH(DEPTH)) u_match1 (
    .entries (mem_r),
    .head    (head_r),
    .count   (count_r),
    .qa      (qa1),
    .hit     (hit1_s),
    .data    (data1_s)
  );

  regfile_bypass_match #(.DEPTH(DEPTH)) u_match2 (
    .entries (mem_r),
    .head    (head_r),
    .count   (count_r),
    .qa      (qa2),
    .hit     (hit2_s),
    .data    (data2_s)
  );

  // Output drive; reset forces every output to its idle value immediately.
  always_comb begin
    wb_ready = ready_s;
    if (rst) begin
      rf_we   = 1'b0;
      rf_wa   = {REG_AW{1'b0}};
      rf_wd   = {XLEN{1'b0}};
      q1_hit  = 1'b0;
      q1_data = {XLEN{1'b0}};
      q2_hit  = 1'b0;
      q2_data = {XLEN{1'b0}};
      count   = {CW{1'b0}};
      empty   = 1'b1;
    end else begin
      rf_we   = !empty_s;
      rf_wa   = empty_s ? {REG_AW{1'b0}} : head_s.rd;
      rf_wd   = empty_s ? {XLEN{1'b0}} : head_s.data;
      q1_hit  = hit1_s;
      q1_data = data1_s;
      q2_hit  = hit2_s;
      q2_data = data2_s;
      count   = count_r;
      empty   = empty_s;
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_regfile_wb_scheduler;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb0_valid, wb1_valid;
  logic [4:0]  wb0_rd, wb1_rd;
  logic [31:0] wb0_data, wb1_data;
  logic        wb_ready;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [4:0]  qa1, qa2;
  logic        q1_hit, q2_hit;
  logic [31:0] q1_data, q2_data;
  logic [2:0]  count;
  logic        empty;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_wb_scheduler #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
    .wb_ready(wb_ready), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .qa1(qa1), .qa2(qa2),
    .q1_hit(q1_hit), .q1_data(q1_data), .q2_hit(q2_hit), .q2_data(q2_data),
    .count(count), .empty(empty)
  );

  typedef struct {
    logic        rst;
    logic        v0;
    logic [4:0]  rd0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  rd1;
    logic [31:0] d1;
    logic [4:0]  qa;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ready;
    logic [2:0]  cnt;
    logic        hit;
    logic [31:0] hdata;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  vec_t tbl[11];
  ent_t model_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic v0, input logic [4:0] rd0,
                              input logic [31:0] d0, input logic v1, input logic [4:0] rd1,
                              input logic [31:0] d1, input logic [4:0] qa, input logic we,
                              input logic [4:0] wa, input logic [31:0] wd, input logic ready,
                              input logic [2:0] cnt, input logic hit, input logic [31:0] hdata);
    vec_t v;
    v.rst = r; v.v0 = v0; v.rd0 = rd0; v.d0 = d0; v.v1 = v1; v.rd1 = rd1; v.d1 = d1;
    v.qa = qa; v.we = we; v.wa = wa; v.wd = wd; v.ready = ready; v.cnt = cnt;
    v.hit = hit; v.hdata = hdata;
    return v;
  endfunction

  task automatic drive(input logic r, input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
                       input logic [4:0] a1, input logic [4:0] a2);
    rst = r;
    wb0_valid = v0; wb0_rd = rd0; wb0_data = d0;
    wb1_valid = v1; wb1_rd = rd1; wb1_data = d1;
    qa1 = a1; qa2 = a2;
  endtask

  function automatic logic [32:0] model_lookup(input logic [4:0] qa);
    logic [32:0] res;
    res = 33'd0;
    if (qa != 5'd0) begin
      foreach (model_q[i]) begin
        if (model_q[i].rd == qa) res = {1'b1, model_q[i].data};
      end
    end
    return res;
  endfunction

  // One cycle against the model: drive, check pre-edge outputs, clock, update the model.
  task automatic step(input logic r, input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
                      input logic [4:0] a1, input logic [4:0] a2);
    logic        e_ready;
    logic [37:0] e_rf;
    logic [32:0] e_q1, e_q2;
    int          sz;
    drive(r, v0, rd0, d0, v1, rd1, d1, a1, a2);
    #1;
    sz = model_q.size();
    if (r) begin
      e_ready = 1'b0; e_rf = 38'd0; e_q1 = 33'd0; e_q2 = 33'd0; sz = 0;
    end else begin
      e_ready = ((DEPTH - sz) >= 2);
      e_rf    = (sz != 0) ? {1'b1, model_q[0].rd, model_q[0].data} : 38'd0;
      e_q1    = model_lookup(a1);
      e_q2    = model_lookup(a2);
    end
    check("m_rf_port", {rf_we, rf_wa, rf_wd}, e_rf);
    check("m_ready", wb_ready, e_ready);
    check("m_count_empty", {count, empty}, {3'(sz), (sz == 0)});
    check("m_q1", {q1_hit, q1_data}, e_q1);
    check("m_q2", {q2_hit, q2_data}, e_q2);
    @(posedge clk);
    if (r) begin
      model_q.delete();
    end else begin
      if (model_q.size() != 0) void'(model_q.pop_front());
      if (e_ready && v0 && rd0 != 5'd0) model_q.push_back('{rd: rd0, data: d0});
      if (e_ready && v1 && rd1 != 5'd0) model_q.push_back('{rd: rd1, data: d1});
    end
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = mk(1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd0, 1'b0, 5'd0, 32'h0,  1'b0, 3'd0, 1'b0, 32'h0);
    tbl[1]  = mk(1'b0, 1'b1, 5'd5, 32'hA5, 1'b0, 5'd0, 32'h0, 5'd5, 1'b0, 5'd0, 32'h0,  1'b1, 3'd0, 1'b0, 32'h0);
    tbl[2]  = mk(1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd5, 1'b1, 5'd5, 32'hA5, 1'b1, 3'd1, 1'b1, 32'hA5);
    tbl[3]  = mk(1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd5, 1'b0, 5'd0, 32'h0,  1'b1, 3'd0, 1'b0, 32'h0);
    tbl[4]  = mk(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 5'd3, 1'b0, 5'd0, 32'h0, 1'b1, 3'd0, 1'b0, 32'h0);
    tbl[5]  = mk(1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd3, 1'b1, 5'd3, 32'h11, 1'b1, 3'd2, 1'b1, 32'h22);
    tbl[6]  = mk(1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd3, 1'b1, 5'd3, 32'h22, 1'b1, 3'd1, 1'b1, 32'h22);
    tbl[7]  = mk(1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd3, 1'b0, 5'd0, 32'h0,  1'b1, 3'd0, 1'b0, 32'h0);
    tbl[8]  = mk(1'b0, 1'b1, 5'd0, 32'hFF, 1'b1, 5'd7, 32'h1, 5'd0, 1'b0, 5'd0, 32'h0,  1'b1, 3'd0, 1'b0, 32'h0);
    tbl[9]  = mk(1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd0, 1'b1, 5'd7, 32'h1,  1'b1, 3'd1, 1'b0, 32'h0);
    tbl[10] = mk(1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd7, 1'b0, 5'd0, 32'h0,  1'b1, 3'd0, 1'b0, 32'h0);

    // Directed table: expectations are the outputs seen before each row's edge.
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].v0, tbl[i].rd0, tbl[i].d0, tbl[i].v1, tbl[i].rd1, tbl[i].d1,
            tbl[i].qa, tbl[i].qa);
      #1;
      check($sformatf("t%0d_rf", i), {rf_we, rf_wa, rf_wd}, {tbl[i].we, tbl[i].wa, tbl[i].wd});
      check($sformatf("t%0d_ready", i), wb_ready, tbl[i].ready);
      check($sformatf("t%0d_count", i), {count, empty}, {tbl[i].cnt, (tbl[i].cnt == 3'd0)});
      check($sformatf("t%0d_q1", i), {q1_hit, q1_data}, {tbl[i].hit, tbl[i].hdata});
      check($sformatf("t%0d_q2", i), {q2_hit, q2_data}, {tbl[i].hit, tbl[i].hdata});
      @(posedge clk);
      @(negedge clk);
    end

    // Resync the model with a reset cycle.
    step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Back-to-back dual pushes fill the queue; the held request lands once room frees.
    step(1'b0, 1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h102, 5'd1, 5'd2);
    step(1'b0, 1'b1, 5'd3, 32'h103, 1'b1, 5'd4, 32'h104, 5'd3, 5'd4);
    #1;
    check("full_count_ready", {wb_ready, count}, {1'b0, 3'd3});
    step(1'b0, 1'b1, 5'd5, 32'h105, 1'b1, 5'd6, 32'h106, 5'd4, 5'd5);
    check("refill_ready", {wb_ready, count}, {1'b1, 3'd2});
    step(1'b0, 1'b1, 5'd5, 32'h105, 1'b1, 5'd6, 32'h106, 5'd5, 5'd6);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd6, 5'd5);

    // Reset mid-drain with three entries queued: none of them may be written.
    step(1'b0, 1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hA1, 5'd10, 5'd11);
    step(1'b0, 1'b1, 5'd12, 32'hA2, 1'b1, 5'd13, 32'hA3, 5'd12, 5'd13);
    check("pre_reset_count", count, 3'd3);
    step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd12, 5'd13);
    check("post_reset", {rf_we, count, empty}, {1'b0, 3'd0, 1'b1});
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd11, 5'd13);

    // Continuous single-lane stream: steady state of one entry, pointers wrap.
    for (int i = 0; i < 20; i++) begin
      logic [4:0] rd;
      rd = 5'((i % 31) + 1);
      if (i % 2 == 0) step(1'b0, 1'b1, rd, 32'(1000 + i), 1'b0, 5'd0, 32'h0, rd, 5'd0);
      else            step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, rd, 32'(1000 + i), rd, 5'd0);
      check("stream_steady", {rf_we, count}, {1'b1, 3'd1});
    end
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Randomized traffic against the model, small register range to force hits.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
